// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter FSM encoding, frame geometry, command bytes
// and the odd-parity helper used by both the host transmit and receive paths.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_REQ       = 3'd2,
    ST_SEND      = 3'd3,
    ST_ACK       = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } tx_state_e;

  // Full frame is start + 8 data + parity + stop; the shifter holds everything after start.
  localparam int unsigned FRAME_LEN = 11;
  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned SHIFT_LEN = FRAME_LEN - 1;

  localparam logic [7:0] CMD_RESET       = 8'hFF;
  localparam logic [7:0] CMD_ENABLE      = 8'hF4;
  localparam logic [7:0] CMD_SET_DEFAULT = 8'hF6;
  localparam logic [7:0] ACK_BYTE        = 8'hFA;

  function automatic logic odd_parity(input logic [DATA_BITS-1:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// PS/2 line conditioner: 2-flop synchronizer, FILTER_LEN-sample glitch filter and a
// one-cycle fall strobe on the filtered level. Shared with the receive path.
module ps2_clk_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic line_i,
  output logic sync_o,
  output logic level_o,
  output logic fall_o
);

  localparam int unsigned CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic [1:0]    sync_q;
  logic          level_q;
  logic          fall_q;
  logic [CW-1:0] cnt_q;

  // NOTE: the synchronizer and filtered level reset to 1, the idle level of an
  // open-drain bus, so leaving reset never produces a false fall strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q  <= 2'b11;
      level_q <= 1'b1;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      // NOTE: every register here uses <= so all flops sample the same pre-edge values.
      sync_q <= {sync_q[0], line_i};
      fall_q <= 1'b0;
      if (sync_q[1] == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        level_q <= sync_q[1];
        fall_q  <= ~sync_q[1];
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign sync_o  = sync_q[1];
  assign level_o = level_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter driving PS2_CLK/PS2_DATA open-drain.
// Define PS2_TX_RETRY_EN to retry a NACKed or timed-out byte up to MAX_RETRY times.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_HZ         = 100_000_000,
  parameter int unsigned INHIBIT_CYCLES = CLK_HZ / 1_000_000 * 120,
  parameter int unsigned TIMEOUT_CYCLES = CLK_HZ / 1_000 * 15,
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned MAX_RETRY      = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES
                                                                      : INHIBIT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       LAST_SHIFT = 4'(SHIFT_LEN - 1);

`ifdef PS2_TX_RETRY_EN
  localparam int unsigned RETRIES = MAX_RETRY;
`else
  localparam int unsigned RETRIES = 0;
`endif
  localparam logic [3:0] RETRY_LIMIT = 4'(RETRIES);

  logic clk_fall, clk_lvl, clk_sync_unused;
  logic data_sync, data_lvl, data_fall_unused;

  ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk     (clk),
    .rst     (rst),
    .line_i  (ps2_clk_in),
    .sync_o  (clk_sync_unused),
    .level_o (clk_lvl),
    .fall_o  (clk_fall)
  );

  ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
    .clk     (clk),
    .rst     (rst),
    .line_i  (ps2_data_in),
    .sync_o  (data_sync),
    .level_o (data_lvl),
    .fall_o  (data_fall_unused)
  );

  tx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [SHIFT_LEN-1:0] shreg_q, shreg_d;
  logic [7:0]           byte_q, byte_d;
  logic                 nack_q, nack_d;
  logic [3:0]           retry_q, retry_d;
  logic                 clk_oe_q, clk_oe_d;
  logic                 data_oe_q, data_oe_d;
  logic                 done, fail, err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '1;
      byte_q    <= '0;
      nack_q    <= 1'b0;
      retry_q   <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      byte_q    <= byte_d;
      nack_q    <= nack_d;
      retry_q   <= retry_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
    end
  end

  // Line enables are computed for the next state and registered so the pads never glitch.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    byte_d    = byte_q;
    nack_d    = nack_q;
    retry_d   = retry_q;
    clk_oe_d  = 1'b0;
    data_oe_d = 1'b0;
    done      = 1'b0;
    fail      = 1'b0;
    err       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (tx_valid) begin
          byte_d   = tx_data;
          retry_d  = '0;
          clk_oe_d = 1'b1;
          state_d  = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        clk_oe_d = 1'b1;
        if (cnt_q == INH_LAST) begin
          data_oe_d = 1'b1;
          state_d   = ST_REQ;
        end
      end
      ST_REQ: begin
        data_oe_d = 1'b1;
        cnt_d     = '0;
        bit_cnt_d = '0;
        nack_d    = 1'b0;
        shreg_d   = {1'b1, odd_parity(byte_q), byte_q};
        state_d   = ST_SEND;
      end
      ST_SEND: begin
        data_oe_d = data_oe_q;
        if (clk_fall) begin
          cnt_d     = '0;
          data_oe_d = ~shreg_q[0];
          shreg_d   = {1'b1, shreg_q[SHIFT_LEN-1:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LAST_SHIFT) state_d = ST_ACK;
        end else if (cnt_q == TO_LAST) begin
          fail = 1'b1;
        end
      end
      ST_ACK: begin
        if (clk_fall) begin
          cnt_d   = '0;
          nack_d  = data_sync;
          state_d = ST_WAIT_IDLE;
        end else if (cnt_q == TO_LAST) begin
          fail = 1'b1;
        end
      end
      ST_WAIT_IDLE: begin
        if (clk_lvl && data_lvl) begin
          if (nack_q) begin
            fail = 1'b1;
          end else begin
            done    = 1'b1;
            state_d = ST_IDLE;
          end
        end else if (cnt_q == TO_LAST) begin
          fail = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A failed attempt either restarts from INHIBIT with the latched byte or reports once.
    if (fail) begin
      cnt_d     = '0;
      data_oe_d = 1'b0;
      if (retry_q != RETRY_LIMIT) begin
        retry_d  = retry_q + 1'b1;
        clk_oe_d = 1'b1;
        state_d  = ST_INHIBIT;
      end else begin
        err      = 1'b1;
        clk_oe_d = 1'b0;
        state_d  = ST_IDLE;
      end
    end
  end

  assign tx_ready    = (state_q == ST_IDLE);
  assign tx_busy     = (state_q != ST_IDLE);
  assign tx_done     = done;
  assign tx_err      = err;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;

endmodule
